// File: rtl/core_test_pkg.sv
// core_test_pkg: shared state/verdict types and address helper for the core test sequencer.
package core_test_pkg;
   localparam int MAX_TESTS = 32;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;
   typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_TMO} verdict_t;
   // Address i of a flat table, zero-extended to MAX_TESTS entries by the caller.
   function automatic logic [31:0] pc_at(input logic [MAX_TESTS*32-1:0] flat, input int unsigned i);
      return 32'(flat >> (32 * i));
   endfunction
endpackage

// File: rtl/core_test_monitor_if.sv
// core_test_monitor_if: handshake and verdict bundle between the test monitor and its environment.
interface core_test_monitor_if #(parameter int NUM_TESTS = 3);
   localparam int IW = NUM_TESTS > 1 ? $clog2(NUM_TESTS) : 1;
   logic start, pc_valid, load_ack, core_rst, load_req, busy, done;
   logic [31:0] pc;
   logic [IW-1:0] load_idx;
   logic [NUM_TESTS-1:0] pass_mask, fail_mask, tmo_mask;
   modport master (
      input  start, pc, pc_valid, load_ack,
      output core_rst, load_req, load_idx, busy, done, pass_mask, fail_mask, tmo_mask
   );
   modport slave (
      output start, pc, pc_valid, load_ack,
      input  core_rst, load_req, load_idx, busy, done, pass_mask, fail_mask, tmo_mask
   );
endinterface

// File: rtl/test_watchdog.sv
// test_watchdog: RUN-phase cycle watchdog plus consecutive pass-address hold counter.
module test_watchdog #(
   parameter int TIMEOUT   = 10000,
   parameter int PASS_HOLD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_pass_hit,
   input  logic i_pc_valid,
   output logic o_tmo,
   output logic o_pass_ok
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int HW = $clog2(PASS_HOLD + 1);
   logic [CW-1:0] r_cnt;
   logic [HW-1:0] r_hold;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt  <= '0;
         r_hold <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_hold <= '0;
      end else if (i_enable) begin
         r_cnt <= (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
         if (i_pc_valid)
            r_hold <= !i_pass_hit ? '0 : (r_hold == HW'(PASS_HOLD)) ? r_hold : r_hold + 1'b1;
      end
   // Both verdicts fire on the sampling edge itself so the mask lands one cycle later.
   assign o_tmo     = i_enable && r_cnt == CW'(TIMEOUT - 1);
   assign o_pass_ok = i_enable && i_pc_valid && i_pass_hit && r_hold == HW'(PASS_HOLD - 1);
endmodule

// File: rtl/core_test_monitor.sv
// core_test_monitor: runs NUM_TESTS core programs back to back (reset, load, run)
// and records a pass/fail/timeout verdict per test.
module core_test_monitor
   import core_test_pkg::*;
#(
   parameter int NUM_TESTS = 3,
   parameter logic [NUM_TESTS*32-1:0] PASS_PCS = {32'h2D68, 32'h2A7C, 32'h22CC},
   parameter logic [NUM_TESTS*32-1:0] FAIL_PCS = {32'h2D64, 32'h2A78, 32'h22C8},
   parameter int TIMEOUT      = 10000,
   parameter int RST_CYCLES   = 2,
   parameter int PASS_HOLD    = 2,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input logic clk,
   input logic rst,
   core_test_monitor_if.master bus
);
   localparam int IW = NUM_TESTS > 1 ? $clog2(NUM_TESTS) : 1;
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [MAX_TESTS*32-1:0] P_PASS = (MAX_TESTS*32)'(PASS_PCS);
   localparam logic [MAX_TESTS*32-1:0] P_FAIL = (MAX_TESTS*32)'(FAIL_PCS);
   state_t r_state, w_nxt;
   verdict_t w_verdict;
   logic [IW-1:0] r_idx;
   logic [RW-1:0] r_rcnt;
   logic r_core_rst, r_load_req, r_busy, r_done, r_bad;
   logic [NUM_TESTS-1:0] r_pass, r_fail, r_tmo;
   logic w_run, w_fail_hit, w_pass_hit, w_tmo, w_pass_ok, w_last, w_start;
   assign w_run      = r_state == S_RUN;
   assign w_fail_hit = bus.pc_valid && bus.pc == pc_at(P_FAIL, 32'(r_idx));
   assign w_pass_hit = bus.pc == pc_at(P_PASS, 32'(r_idx));
   assign w_last     = r_idx == IW'(NUM_TESTS - 1);
   assign w_start    = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   test_watchdog #(.TIMEOUT(TIMEOUT), .PASS_HOLD(PASS_HOLD)) u_wd (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (!w_run),
      .i_enable  (w_run),
      .i_pass_hit(w_pass_hit),
      .i_pc_valid(bus.pc_valid),
      .o_tmo     (w_tmo),
      .o_pass_ok (w_pass_ok)
   );
   always_comb begin
      w_verdict = !w_run ? V_NONE : w_fail_hit ? V_FAIL : w_pass_ok ? V_PASS : w_tmo ? V_TMO : V_NONE;
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (bus.start) w_nxt = S_RESET;
         S_RESET:        if (r_rcnt == RW'(RST_CYCLES - 1)) w_nxt = S_LOAD;
         S_LOAD:         if (bus.load_ack) w_nxt = S_RUN;
         S_RUN:          if (w_verdict != V_NONE) w_nxt = S_NEXT;
         S_NEXT:         w_nxt = (w_last || (STOP_ON_FAIL && r_bad)) ? S_DONE : S_RESET;
         default:        w_nxt = S_IDLE;
      endcase
   end
   // Outputs are decoded from the next state so they are registered alongside it.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_rcnt     <= '0;
         r_core_rst <= 1'b1;
         r_load_req <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bad      <= 1'b0;
         r_pass     <= '0;
         r_fail     <= '0;
         r_tmo      <= '0;
      end else begin
         r_state    <= w_nxt;
         r_core_rst <= w_nxt != S_RUN;
         r_load_req <= w_nxt == S_LOAD;
         r_busy     <= !(w_nxt inside {S_IDLE, S_DONE});
         r_done     <= w_nxt == S_DONE;
         r_rcnt     <= r_state == S_RESET ? r_rcnt + 1'b1 : '0;
         if (w_start) begin
            r_idx  <= '0;
            r_pass <= '0;
            r_fail <= '0;
            r_tmo  <= '0;
         end
         if (w_verdict != V_NONE) begin
            r_bad         <= w_verdict != V_PASS;
            r_pass[r_idx] <= w_verdict == V_PASS;
            r_fail[r_idx] <= w_verdict == V_FAIL;
            r_tmo[r_idx]  <= w_verdict == V_TMO;
         end
         if (r_state == S_NEXT && w_nxt == S_RESET) r_idx <= r_idx + 1'b1;
      end
   assign bus.core_rst  = r_core_rst;
   assign bus.load_req  = r_load_req;
   assign bus.load_idx  = r_idx;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass_mask = r_pass;
   assign bus.fail_mask = r_fail;
   assign bus.tmo_mask  = r_tmo;
endmodule

// File: tb/tb_core_test_monitor.sv
// tb_core_test_monitor: randomized scenario bench; verdicts are predicted by scanning the
// generated PC stream against the pass/fail/timeout rules.
module tb_core_test_monitor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   bit sel = 1'b0;
   logic start_s = 1'b0, pcv_s = 1'b0, ack_s = 1'b0;
   logic [31:0] pc_s = '0;
   logic [31:0] pass_pc [3] = '{32'h22CC, 32'h2A7C, 32'h2D68};
   logic [31:0] fail_pc [3] = '{32'h22C8, 32'h2A78, 32'h2D64};
   bit st_v [64];
   logic [31:0] st_pc [64];
   core_test_monitor_if #(.NUM_TESTS(3)) ifa ();
   core_test_monitor_if #(.NUM_TESTS(3)) ifb ();
   assign ifa.start    = !sel && start_s;
   assign ifa.pc_valid = !sel && pcv_s;
   assign ifa.load_ack = !sel && ack_s;
   assign ifa.pc       = pc_s;
   assign ifb.start    = sel && start_s;
   assign ifb.pc_valid = sel && pcv_s;
   assign ifb.load_ack = sel && ack_s;
   assign ifb.pc       = pc_s;
   core_test_monitor #(.TIMEOUT(50)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   core_test_monitor #(.TIMEOUT(40), .PASS_HOLD(3), .RST_CYCLES(3), .STOP_ON_FAIL(1'b0)) u_b (
      .clk(clk), .rst(rst), .bus(ifb));
   logic m_core_rst, m_load_req, m_busy, m_done;
   logic [1:0] m_idx;
   logic [2:0] m_pass, m_fail, m_tmo;
   assign m_core_rst = sel ? ifb.core_rst  : ifa.core_rst;
   assign m_load_req = sel ? ifb.load_req  : ifa.load_req;
   assign m_busy     = sel ? ifb.busy      : ifa.busy;
   assign m_done     = sel ? ifb.done      : ifa.done;
   assign m_idx      = sel ? ifb.load_idx  : ifa.load_idx;
   assign m_pass     = sel ? ifb.pass_mask : ifa.pass_mask;
   assign m_fail     = sel ? ifb.fail_mask : ifa.fail_mask;
   assign m_tmo      = sel ? ifb.tmo_mask  : ifa.tmo_mask;

   function automatic int tmo_of(bit s);  return s ? 40 : 50; endfunction
   function automatic int hold_of(bit s); return s ? 3 : 2;   endfunction
   function automatic int rst_of(bit s);  return s ? 3 : 2;   endfunction
   function automatic bit sof_of(bit s);  return !s;          endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind 0: pass burst, 1: fail hit, 2: no match (timeout), 3: pass / other / pass / pass
   task automatic build(input bit s, input int idx, input int kind);
      int n, len;
      for (int k = 0; k < 64; k++) begin
         st_v[k]  = 1'($urandom_range(0, 1));
         st_pc[k] = $urandom | 32'h0001_0000;
      end
      n = 0;
      len = (kind == 3) ? 0 : int'($urandom_range(0, 6));
      while (n < len) begin
         case ($urandom_range(0, 3))
            0: begin st_v[n] = 1'b1; st_pc[n] = pass_pc[idx]; st_v[n+1] = 1'b1; n += 2; end
            1: begin st_v[n] = 1'b0; st_pc[n] = fail_pc[idx]; n++; end
            2: begin st_v[n] = 1'b1; st_pc[n] = pass_pc[(idx + 1) % 3]; n++; end
            default: n++;
         endcase
      end
      if (kind == 0)
         for (int h = 0; h < hold_of(s); h++) begin
            if ($urandom_range(0, 1) == 1) begin st_v[n] = 1'b0; st_pc[n] = pass_pc[idx]; n++; end
            st_v[n] = 1'b1; st_pc[n] = pass_pc[idx]; n++;
         end
      else if (kind == 1) begin
         st_v[n] = 1'b1; st_pc[n] = fail_pc[idx];
      end else if (kind == 3) begin
         st_v[0] = 1'b1; st_pc[0] = pass_pc[idx];
         st_v[1] = 1'b1;
         st_v[2] = 1'b1; st_pc[2] = pass_pc[idx];
         st_v[3] = 1'b1; st_pc[3] = pass_pc[idx];
      end
   endtask

   // vv: 0 pass, 1 fail, 2 timeout; vk: RUN cycle index whose edge registers the verdict
   task automatic predict(input bit s, input int idx, output int vk, output int vv);
      int streak;
      streak = 0;
      vk = tmo_of(s) - 1;
      vv = 2;
      for (int k = 0; k < tmo_of(s); k++) begin
         if (st_v[k] && st_pc[k] == fail_pc[idx]) begin vk = k; vv = 1; return; end
         if (st_v[k]) streak = (st_pc[k] == pass_pc[idx]) ? streak + 1 : 0;
         if (streak >= hold_of(s)) begin vk = k; vv = 0; return; end
      end
   endtask

   task automatic seq(input bit s, input int k0, input int k1, input int k2, input int rst_at);
      int kd [3];
      logic [2:0] ep, ef, et;
      int n, vk, vv, d;
      kd = '{k0, k1, k2};
      ep = '0; ef = '0; et = '0;
      sel = s;
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      chk("start_busy", 32'(m_busy), 32'd1);
      chk("start_done", 32'(m_done), 32'd0);
      chk("start_masks", 32'({m_pass, m_fail, m_tmo}), 32'd0);
      for (int t = 0; t < 3; t++) begin
         n = 0;
         while (!m_load_req && n < 20) begin
            start_s = 1'($urandom_range(0, 1));
            ack_s = 1'($urandom_range(0, 1));
            pcv_s = 1'b1;
            pc_s = pass_pc[t];
            step();
            n++;
         end
         start_s = 1'b0; ack_s = 1'b0; pcv_s = 1'b0;
         chk("reset_len", 32'(n), 32'(rst_of(s)));
         if (n >= 20) return;
         chk("load_idx", 32'(m_idx), 32'(t));
         chk("load_core_rst", 32'(m_core_rst), 32'd1);
         d = int'($urandom_range(0, 5));
         for (int i = 0; i < d; i++) begin
            start_s = 1'($urandom_range(0, 1));
            pcv_s = 1'b1;
            pc_s = fail_pc[t];
            step();
         end
         start_s = 1'b0; pcv_s = 1'b0;
         chk("load_wait", 32'(m_load_req), 32'd1);
         ack_s = 1'b1;
         step();
         ack_s = 1'b0;
         chk("run_core_rst", 32'(m_core_rst), 32'd0);
         chk("run_load_req", 32'(m_load_req), 32'd0);
         if (rst_at == t) begin
            repeat (3) step();
            #2 rst = 1'b1;
            #1;
            chk("arst_masks", 32'({m_pass, m_fail, m_tmo}), 32'd0);
            chk("arst_core_rst", 32'(m_core_rst), 32'd1);
            chk("arst_busy_done", 32'({m_busy, m_done, m_load_req}), 32'd0);
            chk("arst_idx", 32'(m_idx), 32'd0);
            step();
            rst = 1'b0;
            step();
            chk("arst_idle", 32'({m_busy, m_done, m_core_rst}), 32'd1);
            return;
         end
         build(s, t, kd[t]);
         predict(s, t, vk, vv);
         for (int k = 0; k <= vk; k++) begin
            pcv_s = st_v[k];
            pc_s = st_pc[k];
            start_s = 1'($urandom_range(0, 1));
            step();
            if (k < vk) chk("run_no_verdict", 32'({m_core_rst, m_pass, m_fail, m_tmo}), 32'({1'b0, ep, ef, et}));
         end
         pcv_s = 1'b0; start_s = 1'b0;
         if (vv == 0) ep[t] = 1'b1;
         else if (vv == 1) ef[t] = 1'b1;
         else et[t] = 1'b1;
         chk("verdict_pass", 32'(m_pass), 32'(ep));
         chk("verdict_fail", 32'(m_fail), 32'(ef));
         chk("verdict_tmo", 32'(m_tmo), 32'(et));
         chk("next_core_rst", 32'({m_core_rst, m_busy}), 32'd3);
         step();
         if (t == 2 || (sof_of(s) && vv != 0)) begin
            for (int i = 0; i < 3; i++) begin
               chk("done_flags", 32'({m_done, m_busy, m_core_rst, m_load_req}), 32'b1010);
               chk("done_masks", 32'({m_pass, m_fail, m_tmo}), 32'({ep, ef, et}));
               chk("done_idx", 32'(m_idx), 32'(t));
               step();
            end
            return;
         end
         chk("next_idx", 32'(m_idx), 32'(t + 1));
         chk("next_busy", 32'(m_busy), 32'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (2) step();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_core_rst", 32'(m_core_rst), 32'd1);
         chk("rst_flags", 32'({m_load_req, m_busy, m_done}), 32'd0);
         chk("rst_idx", 32'(m_idx), 32'd0);
         chk("rst_masks", 32'({m_pass, m_fail, m_tmo}), 32'd0);
      end
      rst = 1'b0;
      step();
      seq(1'b0, 0, 0, 0, -1);
      seq(1'b0, 0, 1, 0, -1);
      seq(1'b0, 2, 0, 0, -1);
      seq(1'b0, 3, 0, 0, -1);
      seq(1'b0, 0, 0, 0, 1);
      seq(1'b0, 0, 0, 0, -1);
      seq(1'b1, 0, 1, 0, -1);
      seq(1'b1, 2, 0, 3, -1);
      seq(1'b1, 3, 2, 1, -1);
      for (int r = 0; r < 6; r++)
         seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
